// File: rtl/expu_arbiter_if.sv
// Handshake bundle between the requester stages, the arbiter and the shared EXPU.
// The arbiter uses the slave view; the environment (requesters + EXPU) uses master.
interface expu_arbiter_if #(
  parameter int WIDTH  = 16,
  parameter int N_ROWS = 1,
  parameter int N_REQ  = 2
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // requester side
  logic [N_REQ-1:0]              req_valid_i;
  logic [N_REQ-1:0]              req_ready_o;
  logic [N_REQ-1:0]              req_last_i;
  logic [N_REQ*N_ROWS-1:0]       req_strb_i;
  logic [N_REQ*N_ROWS*WIDTH-1:0] req_op_i;
  logic [N_REQ-1:0]              resp_valid_o;
  logic [N_REQ-1:0]              resp_ready_i;
  logic [N_ROWS-1:0]             resp_strb_o;
  logic [N_ROWS*WIDTH-1:0]       resp_res_o;

  // EXPU side
  logic                          expu_valid_o;
  logic                          expu_ready_i;
  logic [N_ROWS-1:0]             expu_strb_o;
  logic [N_ROWS*WIDTH-1:0]       expu_op_o;
  logic [IDX_W-1:0]              expu_tag_o;
  logic                          expu_valid_i;
  logic                          expu_ready_o;
  logic [N_ROWS-1:0]             expu_strb_i;
  logic [N_ROWS*WIDTH-1:0]       expu_res_i;
  logic [IDX_W-1:0]              expu_tag_i;

  modport slave (
    input  req_valid_i, req_last_i, req_strb_i, req_op_i, resp_ready_i,
    input  expu_ready_i, expu_valid_i, expu_strb_i, expu_res_i, expu_tag_i,
    output req_ready_o, resp_valid_o, resp_strb_o, resp_res_o,
    output expu_valid_o, expu_strb_o, expu_op_o, expu_tag_o, expu_ready_o
  );

  modport master (
    output req_valid_i, req_last_i, req_strb_i, req_op_i, resp_ready_i,
    output expu_ready_i, expu_valid_i, expu_strb_i, expu_res_i, expu_tag_i,
    input  req_ready_o, resp_valid_o, resp_strb_o, resp_res_o,
    input  expu_valid_o, expu_strb_o, expu_op_o, expu_tag_o, expu_ready_o
  );
endinterface

// File: rtl/expu_arbiter.sv
// Shares one EXPU between N_REQ requester stages. Bursts are granted round-robin
// and held until the beat marked last; the requester index rides in the EXPU tag
// so results are steered back. Per-requester credit counters cap in-flight beats.
module expu_arbiter #(
  parameter int WIDTH           = 16,
  parameter int N_ROWS          = 1,
  parameter int N_REQ           = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  input  logic expu_busy_i,
  output logic expu_enable_o,
  output logic expu_clear_o,
  output logic busy_o,
  expu_arbiter_if.slave bus
);
  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int LANE_W = N_ROWS * WIDTH;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] rr_ptr;
  logic [CNT_W-1:0] cnt [N_REQ];

  logic             run;
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] pending;
  logic             found;
  logic [IDX_W-1:0] winner;
  int               idx_sum;
  logic             issue;
  logic             tag_ok;
  logic [N_REQ-1:0] resp_fire;
  logic [N_REQ-1:0] inc;
  logic [N_REQ-1:0] dec;

  assign run           = enable_i & ~rst_i;
  assign expu_enable_o = enable_i;
  assign expu_clear_o  = clear_i | rst_i;
  assign busy_o        = expu_busy_i | (state == LOCKED) | (|pending);

  // Credit check: a requester may only compete while it has room in flight
  always_comb begin
    eligible = '0;
    pending  = '0;
    for (int r = 0; r < N_REQ; r++) begin
      eligible[r] = bus.req_valid_i[r] & (cnt[r] < CNT_W'(MAX_OUTSTANDING));
      pending[r]  = (cnt[r] != '0);
    end
  end

  // Pick the winner: the burst owner while locked, else round-robin from rr_ptr
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    idx_sum = 0;
    if (state == LOCKED) begin
      found  = eligible[owner];
      winner = owner;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        idx_sum = (int'(rr_ptr) + k) % N_REQ;
        if (!found && eligible[idx_sum]) begin
          found  = 1'b1;
          winner = IDX_W'(idx_sum);
        end
      end
    end
  end

  // Forward the granted beat to the EXPU and return ready only to the winner
  always_comb begin
    bus.expu_valid_o = run & found;
    bus.expu_strb_o  = bus.req_strb_i[int'(winner)*N_ROWS +: N_ROWS];
    bus.expu_op_o    = bus.req_op_i[int'(winner)*LANE_W +: LANE_W];
    bus.expu_tag_o   = winner;
    bus.req_ready_o  = '0;
    if (run && found && bus.expu_ready_i)
      bus.req_ready_o[winner] = 1'b1;
    issue = bus.expu_valid_o & bus.expu_ready_i;
  end

  // Route results back by tag; unknown tags are swallowed so the EXPU never stalls
  always_comb begin
    tag_ok           = (int'(bus.expu_tag_i) < N_REQ);
    bus.resp_strb_o  = bus.expu_strb_i;
    bus.resp_res_o   = bus.expu_res_i;
    bus.resp_valid_o = '0;
    resp_fire        = '0;
    for (int r = 0; r < N_REQ; r++) begin
      bus.resp_valid_o[r] = run & bus.expu_valid_i & (bus.expu_tag_i == IDX_W'(r));
      resp_fire[r]        = bus.resp_valid_o[r] & bus.resp_ready_i[r];
    end
    bus.expu_ready_o = run & (tag_ok ? bus.resp_ready_i[bus.expu_tag_i] : 1'b1);
  end

  // Credit movement per requester; a response with nothing pending is ignored
  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 0; r < N_REQ; r++) begin
      inc[r] = issue & (winner == IDX_W'(r));
      dec[r] = resp_fire[r] & pending[r];
    end
  end

  // Burst lock and round-robin pointer update on each accepted beat
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else if (issue) begin
      if (bus.req_last_i[winner]) begin
        state  <= IDLE;
        rr_ptr <= (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
      end else begin
        state <= LOCKED;
        owner <= winner;
      end
    end
  end

  // Outstanding-beat counters: issue adds, returned result removes
  always_ff @(posedge clk_i) begin
    for (int r = 0; r < N_REQ; r++) begin
      if (rst_i || clear_i)
        cnt[r] <= '0;
      else if (inc[r] && !dec[r])
        cnt[r] <= cnt[r] + 1'b1;
      else if (dec[r] && !inc[r])
        cnt[r] <= cnt[r] - 1'b1;
    end
  end

  // Flag results that come back for an idle requester or carry an unknown tag
  always_ff @(posedge clk_i) begin
    if (!rst_i && !clear_i) begin
      assert (!(|(resp_fire & ~pending)));
      assert (!(enable_i && bus.expu_valid_i && !tag_ok));
    end
  end
endmodule

// File: tb/tb_expu_arbiter.sv
// Directed bench for expu_arbiter: N_REQ=2, N_ROWS=1, WIDTH=16, two credits each.
module tb_expu_arbiter;
  localparam int WIDTH = 16;
  localparam int N_ROWS = 1;
  localparam int N_REQ = 2;
  localparam int MAX_OUT = 2;

  logic clk;
  logic rst;
  logic clear;
  logic enable;
  logic expu_busy;
  logic expu_enable;
  logic expu_clear;
  logic busy;

  int checks = 0;
  int errors = 0;

  expu_arbiter_if #(.WIDTH(WIDTH), .N_ROWS(N_ROWS), .N_REQ(N_REQ)) bus ();

  expu_arbiter #(
    .WIDTH(WIDTH), .N_ROWS(N_ROWS), .N_REQ(N_REQ), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .clear_i(clear),
    .enable_i(enable),
    .expu_busy_i(expu_busy),
    .expu_enable_o(expu_enable),
    .expu_clear_o(expu_clear),
    .busy_o(busy),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with traffic present on every input
    rst = 1'b1; clear = 1'b0; enable = 1'b1; expu_busy = 1'b0;
    bus.req_valid_i = 2'b11; bus.req_last_i = 2'b11; bus.req_strb_i = 2'b11;
    bus.req_op_i = {16'h2222, 16'h1111};
    bus.resp_ready_i = 2'b11; bus.expu_ready_i = 1'b1;
    bus.expu_valid_i = 1'b1; bus.expu_tag_i = 1'b0;
    bus.expu_strb_i = 1'b1; bus.expu_res_i = 16'hABCD;
    tick();
    check("rst_req_ready", 32'(bus.req_ready_o), 0);
    check("rst_expu_valid", 32'(bus.expu_valid_o), 0);
    check("rst_expu_ready", 32'(bus.expu_ready_o), 0);
    check("rst_resp_valid", 32'(bus.resp_valid_o), 0);
    check("rst_expu_clear", 32'(expu_clear), 1);
    tick();
    rst = 1'b0; bus.expu_valid_i = 1'b0; bus.req_valid_i = 2'b00;
    #1;
    check("idle_busy", 32'(busy), 0);
    check("idle_clear", 32'(expu_clear), 0);
    check("idle_state", 32'(dut.state), 0);

    // Alternating single-beat bursts
    bus.req_valid_i = 2'b11;
    #1;
    check("rr_tag0", 32'(bus.expu_tag_o), 0);
    check("rr_valid0", 32'(bus.expu_valid_o), 1);
    check("rr_ready0", 32'(bus.req_ready_o), 32'b01);
    check("rr_op0", 32'(bus.expu_op_o), 32'h1111);
    tick();
    check("rr_tag1", 32'(bus.expu_tag_o), 1);
    check("rr_ready1", 32'(bus.req_ready_o), 32'b10);
    check("rr_op1", 32'(bus.expu_op_o), 32'h2222);
    tick();
    check("rr_tag2", 32'(bus.expu_tag_o), 0);
    tick();
    check("rr_tag3", 32'(bus.expu_tag_o), 1);
    tick();
    check("full_valid", 32'(bus.expu_valid_o), 0);
    check("full_ready", 32'(bus.req_ready_o), 0);
    check("full_busy", 32'(busy), 1);
    check("full_cnt0", 32'(dut.cnt[0]), 2);

    // Return results; requester 1 first refuses its result
    bus.req_valid_i = 2'b00; bus.expu_valid_i = 1'b1; bus.expu_tag_i = 1'b0;
    #1;
    check("resp0_valid", 32'(bus.resp_valid_o), 32'b01);
    check("resp0_ready", 32'(bus.expu_ready_o), 1);
    check("resp0_res", 32'(bus.resp_res_o), 32'hABCD);
    tick();
    tick();
    check("drain_cnt0", 32'(dut.cnt[0]), 0);
    bus.expu_tag_i = 1'b1; bus.resp_ready_i = 2'b01;
    #1;
    check("resp1_valid", 32'(bus.resp_valid_o), 32'b10);
    check("resp1_stall", 32'(bus.expu_ready_o), 0);
    tick();
    check("stall_cnt1", 32'(dut.cnt[1]), 2);
    bus.resp_ready_i = 2'b11;
    #1;
    check("resp1_ready", 32'(bus.expu_ready_o), 1);
    tick();
    check("dec_cnt1", 32'(dut.cnt[1]), 1);
    tick();
    bus.expu_valid_i = 1'b0;
    #1;
    check("drain_busy", 32'(busy), 0);

    // Four-beat burst from requester 0 holds off requester 1
    bus.req_valid_i = 2'b11; bus.req_last_i = 2'b10;
    #1;
    check("burst_tag_b1", 32'(bus.expu_tag_o), 0);
    check("burst_ready_b1", 32'(bus.req_ready_o), 32'b01);
    tick();
    bus.expu_valid_i = 1'b1; bus.expu_tag_i = 1'b0;
    #1;
    check("burst_locked", 32'(dut.state), 1);
    check("burst_tag_b2", 32'(bus.expu_tag_o), 0);
    check("burst_ready_b2", 32'(bus.req_ready_o), 32'b01);
    tick();
    check("burst_tag_b3", 32'(bus.expu_tag_o), 0);
    check("burst_ready_b3", 32'(bus.req_ready_o), 32'b01);
    tick();
    bus.req_last_i = 2'b11;
    #1;
    check("burst_tag_b4", 32'(bus.expu_tag_o), 0);
    check("burst_ready_b4", 32'(bus.req_ready_o), 32'b01);
    tick();
    check("burst_next_tag", 32'(bus.expu_tag_o), 1);
    check("burst_next_ready", 32'(bus.req_ready_o), 32'b10);
    check("burst_unlocked", 32'(dut.state), 0);
    tick();
    bus.req_valid_i = 2'b00; bus.expu_tag_i = 1'b1;
    #1;
    check("burst_resp1", 32'(bus.resp_valid_o), 32'b10);
    tick();
    bus.expu_valid_i = 1'b0;
    #1;
    check("burst_cnt0", 32'(dut.cnt[0]), 0);
    check("burst_cnt1", 32'(dut.cnt[1]), 0);

    // Credit exhaustion on requester 0 while its results are held back
    bus.resp_ready_i = 2'b10; bus.req_valid_i = 2'b01;
    #1;
    check("cred_tag_a", 32'(bus.expu_tag_o), 0);
    tick();
    check("cred_tag_b", 32'(bus.expu_tag_o), 0);
    check("cred_valid_b", 32'(bus.expu_valid_o), 1);
    tick();
    bus.req_valid_i = 2'b11;
    #1;
    check("cred_other_tag", 32'(bus.expu_tag_o), 1);
    check("cred_other_ready", 32'(bus.req_ready_o), 32'b10);
    tick();
    bus.req_valid_i = 2'b01; bus.expu_valid_i = 1'b1; bus.expu_tag_i = 1'b0;
    #1;
    check("cred_blocked", 32'(bus.expu_valid_o), 0);
    check("cred_blocked_rdy", 32'(bus.req_ready_o), 0);
    check("cred_resp_valid", 32'(bus.resp_valid_o), 32'b01);
    check("cred_resp_stall", 32'(bus.expu_ready_o), 0);
    tick();
    check("cred_cnt0_held", 32'(dut.cnt[0]), 2);
    bus.resp_ready_i = 2'b11;
    #1;
    check("cred_resp_go", 32'(bus.expu_ready_o), 1);
    check("cred_still_blk", 32'(bus.expu_valid_o), 0);
    tick();
    bus.expu_valid_i = 1'b0; bus.req_last_i = 2'b10;
    #1;
    check("cred_resume", 32'(bus.expu_valid_o), 1);
    check("cred_resume_tag", 32'(bus.expu_tag_o), 0);
    check("cred_resume_rdy", 32'(bus.req_ready_o), 32'b01);
    tick();

    // Soft clear while locked with credits {2,1}
    bus.req_valid_i = 2'b11;
    #1;
    check("lock_state", 32'(dut.state), 1);
    check("lock_valid", 32'(bus.expu_valid_o), 0);
    check("lock_ready", 32'(bus.req_ready_o), 0);
    check("lock_cnt0", 32'(dut.cnt[0]), 2);
    check("lock_cnt1", 32'(dut.cnt[1]), 1);
    clear = 1'b1; expu_busy = 1'b1;
    #1;
    check("clr_expu_clear", 32'(expu_clear), 1);
    tick();
    clear = 1'b0; bus.req_valid_i = 2'b00;
    #1;
    check("clr_state", 32'(dut.state), 0);
    check("clr_cnt0", 32'(dut.cnt[0]), 0);
    check("clr_cnt1", 32'(dut.cnt[1]), 0);
    check("clr_rr", 32'(dut.rr_ptr), 0);
    check("clr_busy_ext", 32'(busy), 1);
    expu_busy = 1'b0;
    #1;
    check("clr_busy_idle", 32'(busy), 0);

    // Global disable freezes everything
    bus.req_last_i = 2'b11; bus.req_valid_i = 2'b10;
    #1;
    check("pre_dis_tag1", 32'(bus.expu_tag_o), 1);
    tick();
    bus.req_valid_i = 2'b01;
    #1;
    check("pre_dis_tag0", 32'(bus.expu_tag_o), 0);
    tick();
    enable = 1'b0; bus.req_valid_i = 2'b11;
    bus.expu_valid_i = 1'b1; bus.expu_tag_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("dis_valid", 32'(bus.expu_valid_o), 0);
      check("dis_ready", 32'(bus.req_ready_o), 0);
      check("dis_resp", 32'(bus.resp_valid_o), 0);
      check("dis_expu_ready", 32'(bus.expu_ready_o), 0);
      check("dis_enable_out", 32'(expu_enable), 0);
      tick();
    end
    check("dis_rr", 32'(dut.rr_ptr), 1);
    check("dis_cnt0", 32'(dut.cnt[0]), 1);
    check("dis_cnt1", 32'(dut.cnt[1]), 1);
    check("dis_state", 32'(dut.state), 0);
    enable = 1'b1; bus.expu_valid_i = 1'b0;
    #1;
    check("en_tag", 32'(bus.expu_tag_o), 1);
    check("en_ready", 32'(bus.req_ready_o), 32'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
